sp_ram_param: RTL and testbench

Parametrised single-port synchronous RAM with a valid/ready request port, per-byte write enables, selectable 1- or 2-cycle read latency, and a hardware clear engine that zeroes the array after reset or on command. It is the general-purpose successor to the fixed 16x8 single-port RAM. It serves as the scratch/buffer memory for datapath blocks in the memory subsystem.

---
 rtl/sp_ram_param.sv | 198 +++++++++++++++++++
 tb/tb_sp_ram_param.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_param.sv
// sp_ram_param: parametrised single-port synchronous RAM.
//
// Requests use a valid/ready handshake with per-byte write enables. Reads are
// read-first and respond after RD_LAT (1 or 2) register stages, without
// backpressure. A clear engine zeroes the whole array after reset and on
// clr_req_i. No request is accepted while the clear engine runs.
//
// Optional feature macro: SP_RAM_PARITY_EN. When it is defined, one even-parity
// bit is stored per byte lane and checked on every read. When it is undefined,
// par_inject_i is ignored and parity_err_o is tied to 0. The port list is the
// same in both builds.
//
// Ports:
//   clk_i, rst_ni        clock; asynchronous active-low reset
//   req_valid_i/ready_o  request handshake (ready only while not clearing)
//   req_we_i             1 = write, 0 = read
//   req_be_i             byte enables for writes
//   req_addr_i           word address
//   req_wdata_i          write data
//   rsp_valid_o          one-cycle pulse per accepted read
//   rsp_rdata_o          read data; holds its value between responses
//   clr_req_i            pulse: start a full-array clear
//   init_done_o          array initialised (same as req_ready_o)
//   par_inject_i         store inverted parity on an accepted write
//   parity_err_o         parity mismatch, qualified by rsp_valid_o
module sp_ram_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [DATA_W/8-1:0] req_be_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_wdata_i,
  output logic                rsp_valid_o,
  output logic [DATA_W-1:0]   rsp_rdata_o,
  input  logic                clr_req_i,
  output logic                init_done_o,
  input  logic                par_inject_i,
  output logic                parity_err_o
);

  localparam int unsigned NumBytes = DATA_W / 8;
  localparam int unsigned Depth    = 2 ** ADDR_W;

  if (RD_LAT != 1 && RD_LAT != 2) begin : gen_bad_rd_lat
    $error("sp_ram_param: RD_LAT must be 1 or 2");
  end
  if (DATA_W % 8 != 0 || DATA_W == 0) begin : gen_bad_data_w
    $error("sp_ram_param: DATA_W must be a non-zero multiple of 8");
  end

  typedef enum logic {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;

  logic                accept, wr_en, rd_en, init_en;
  logic [DATA_W-1:0]   rd_data;
  logic                rd_err;

  // Clear engine: one word per edge; leaves INIT on the edge that writes the
  // last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StInit: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == {ADDR_W{1'b1}}) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (clr_req_i) begin
          state_d = StInit;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready_o = (state_q == StRun);
  assign init_done_o = req_ready_o;
  assign init_en     = (state_q == StInit);
  // A request on the clr_req_i edge is still accepted; a write then gets
  // zeroed by the clear that follows.
  assign accept      = req_valid_i & req_ready_o;
  assign wr_en       = accept & req_we_i;
  assign rd_en       = accept & ~req_we_i;

  // Storage array is not reset; the clear engine initialises it instead.
  logic [DATA_W-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (init_en) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (req_be_i[i]) begin
          mem_q[req_addr_i][8*i +: 8] <= req_wdata_i[8*i +: 8];
        end
      end
    end
  end

  // Read-first: the word as it stood before the accepting edge.
  assign rd_data = mem_q[req_addr_i];

`ifdef SP_RAM_PARITY_EN
  logic [NumBytes-1:0] par_q [Depth];
  logic [NumBytes-1:0] rd_par;

  always_ff @(posedge clk_i) begin
    if (init_en) begin
      par_q[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (req_be_i[i]) begin
          par_q[req_addr_i][i] <= (^req_wdata_i[8*i +: 8]) ^ par_inject_i;
        end
      end
    end
  end

  always_comb begin
    rd_par = par_q[req_addr_i];
    rd_err = 1'b0;
    for (int unsigned i = 0; i < NumBytes; i++) begin
      rd_err = rd_err | (rd_par[i] ^ (^rd_data[8*i +: 8]));
    end
  end
`else
  logic unused_par_inject;
  assign unused_par_inject = par_inject_i;
  assign rd_err            = 1'b0;
`endif

  // First response stage; the error flag is only ever set alongside valid.
  logic              s1_valid_q, s1_err_q;
  logic [DATA_W-1:0] s1_data_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= rd_en;
      s1_err_q   <= rd_en & rd_err;
      if (rd_en) begin
        s1_data_q <= rd_data;
      end
    end
  end

  if (RD_LAT == 2) begin : gen_lat2
    logic              s2_valid_q, s2_err_q;
    logic [DATA_W-1:0] s2_data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s1_valid_q;
        s2_err_q   <= s1_err_q;
        if (s1_valid_q) begin
          s2_data_q <= s1_data_q;
        end
      end
    end

    assign rsp_valid_o  = s2_valid_q;
    assign rsp_rdata_o  = s2_data_q;
    assign parity_err_o = s2_err_q;
  end else begin : gen_lat1
    assign rsp_valid_o  = s1_valid_q;
    assign rsp_rdata_o  = s1_data_q;
    assign parity_err_o = s1_err_q;
  end

endmodule

// File: tb/tb_sp_ram_param.sv
// Bench for sp_ram_param: one RD_LAT=1 and one RD_LAT=2 instance share the same
// request stimulus; each has its own queue of expected responses, which is
// filled when a read is accepted and drained by a monitor on the falling edge.
module tb_sp_ram_param;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 4;
  localparam int unsigned Depth = 16;
`ifdef SP_RAM_PARITY_EN
  localparam bit PerrEn = 1'b1;
`else
  localparam bit PerrEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_we, clr_req, par_inject;
  logic [1:0]    req_be;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;

  logic          ready1, rv1, done1, perr1;
  logic [DW-1:0] rd1;
  logic          ready2, rv2, done2, perr2;
  logic [DW-1:0] rd2;

  always #5 clk = ~clk;

  sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv1), .rsp_rdata_o(rd1), .clr_req_i(clr_req), .init_done_o(done1),
    .par_inject_i(par_inject), .parity_err_o(perr1)
  );

  sp_ram_param #(.DATA_W(DW), .ADDR_W(AW), .RD_LAT(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(ready2),
    .req_we_i(req_we), .req_be_i(req_be), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rv2), .rsp_rdata_o(rd2), .clr_req_i(clr_req), .init_done_o(done2),
    .par_inject_i(par_inject), .parity_err_o(perr2)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
    int            at;
  } exp_t;

  typedef struct {
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic          inj;
    logic [DW-1:0] exp_d;
    logic          exp_e;
  } vec_t;

  exp_t          q1[$], q2[$];
  exp_t          e1, e2;
  vec_t          vecs [11];
  logic [DW-1:0] mdl   [Depth];
  logic [1:0]    mdl_p [Depth];
  int            total = 0;
  int            bad = 0;
  int            edge_n = 0;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < Depth; i++) begin
      mdl[i]   = '0;
      mdl_p[i] = '0;
    end
  endtask

  // Drive one request for one edge; expectations come from the model unless
  // use_tab supplies hand-derived values.
  task automatic drive(input logic we, input logic [1:0] be, input logic [AW-1:0] a,
                       input logic [DW-1:0] wd, input logic inj, input logic clr,
                       input logic use_tab, input logic [DW-1:0] tab_d, input logic tab_e);
    exp_t x;
    logic acc;
    req_valid  = 1'b1;
    req_we     = we;
    req_be     = be;
    req_addr   = a;
    req_wdata  = wd;
    par_inject = inj;
    clr_req    = clr;
    acc        = ready1;
    if (acc && !we) begin
      x.d  = use_tab ? tab_d : mdl[a];
      x.e  = PerrEn & (use_tab ? tab_e : |mdl_p[a]);
      x.at = edge_n + 1;
      q1.push_back(x);
      q2.push_back(x);
    end
    if (acc && we) begin
      for (int i = 0; i < 2; i++) begin
        if (be[i]) begin
          mdl[a][8*i +: 8] = wd[8*i +: 8];
          mdl_p[a][i]      = inj;
        end
      end
    end
    if (acc && clr) model_clear();
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    clr_req    = 1'b0;
    par_inject = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] wd);
    drive(1'b1, 2'b11, a, wd, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    drive(1'b0, 2'b00, a, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called just after the edge that started a clear (or right after reset
  // release): ready stays low through DEPTH-1 more edges, rises after DEPTH.
  task automatic check_init(input string nm);
    repeat (Depth - 1) @(posedge clk);
    #1;
    chk({nm, "_busy_ready1"}, 32'(ready1), 0);
    chk({nm, "_busy_ready2"}, 32'(ready2), 0);
    chk({nm, "_busy_done1"}, 32'(done1), 0);
    @(posedge clk);
    #1;
    chk({nm, "_ready1"}, 32'(ready1), 1);
    chk({nm, "_ready2"}, 32'(ready2), 1);
    chk({nm, "_done2"}, 32'(done2), 1);
  endtask

  always @(negedge clk) begin
    if (rv1) begin
      if (q1.size() == 0) begin
        chk("rsp1_unexpected", 1, 0);
      end else begin
        e1 = q1.pop_front();
        chk("rsp1_data", 32'(rd1), 32'(e1.d));
        chk("rsp1_perr", 32'(perr1), 32'(e1.e));
        chk("rsp1_latency", 32'(edge_n - e1.at), 0);
      end
    end else if (perr1) begin
      chk("rsp1_perr_unqualified", 32'(perr1), 0);
    end
  end

  always @(negedge clk) begin
    if (rv2) begin
      if (q2.size() == 0) begin
        chk("rsp2_unexpected", 1, 0);
      end else begin
        e2 = q2.pop_front();
        chk("rsp2_data", 32'(rd2), 32'(e2.d));
        chk("rsp2_perr", 32'(perr2), 32'(e2.e));
        chk("rsp2_latency", 32'(edge_n - e2.at), 1);
      end
    end else if (perr2) begin
      chk("rsp2_perr_unqualified", 32'(perr2), 0);
    end
  end

  initial begin
    //          we    be     addr  wdata     inj   exp_d     exp_e
    vecs[0]  = '{1'b1, 2'b11, 4'd3, 16'hA5A5, 1'b0, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 2'b01, 4'd3, 16'h1234, 1'b0, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 2'b00, 4'd3, 16'h0000, 1'b0, 16'hA534, 1'b0};
    vecs[3]  = '{1'b1, 2'b00, 4'd3, 16'hFFFF, 1'b0, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 2'b00, 4'd3, 16'h0000, 1'b0, 16'hA534, 1'b0};
    vecs[5]  = '{1'b1, 2'b11, 4'd9, 16'h00FF, 1'b1, 16'h0000, 1'b0};
    vecs[6]  = '{1'b0, 2'b00, 4'd9, 16'h0000, 1'b0, 16'h00FF, 1'b1};
    vecs[7]  = '{1'b1, 2'b11, 4'd9, 16'h00FF, 1'b0, 16'h0000, 1'b0};
    vecs[8]  = '{1'b0, 2'b00, 4'd9, 16'h0000, 1'b0, 16'h00FF, 1'b0};
    vecs[9]  = '{1'b1, 2'b10, 4'd9, 16'h8001, 1'b1, 16'h0000, 1'b0};
    vecs[10] = '{1'b0, 2'b00, 4'd9, 16'h0000, 1'b0, 16'h80FF, 1'b1};

    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_be     = '0;
    req_addr   = '0;
    req_wdata  = '0;
    clr_req    = 1'b0;
    par_inject = 1'b0;
    model_clear();

    #3;
    chk("reset_ready1", 32'(ready1), 0);
    chk("reset_ready2", 32'(ready2), 0);
    chk("reset_rv1", 32'(rv1), 0);
    chk("reset_rv2", 32'(rv2), 0);
    chk("reset_rdata1", 32'(rd1), 0);
    chk("reset_rdata2", 32'(rd2), 0);
    chk("reset_perr1", 32'(perr1), 0);
    chk("reset_perr2", 32'(perr2), 0);

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_init("init");
    for (int a = 0; a < Depth; a++) rd(AW'(a));
    idle(3);

    // Byte enables and parity, table driven.
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].wd, vecs[i].inj, 1'b0,
            1'b1, vecs[i].exp_d, vecs[i].exp_e);
    end
    idle(3);

    // Streaming: back-to-back writes then back-to-back reads.
    for (int a = 0; a < Depth; a++) wr(AW'(a), DW'(16'h1111 * a));
    for (int a = 0; a < Depth; a++) rd(AW'(a));
    idle(3);

    // Clear collision: read of 5 in flight, then clr together with a write to 6.
    rd(4'd5);
    drive(1'b1, 2'b11, 4'd6, 16'hBEEF, 1'b0, 1'b1, 1'b0, '0, 1'b0);
    check_init("clr");
    rd(4'd5);
    rd(4'd6);
    idle(3);

    // Reset mid-stream with two reads in flight.
    wr(4'd2, 16'h2222);
    rd(4'd2);
    rd(4'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rv1", 32'(rv1), 0);
    chk("midrst_rv2", 32'(rv2), 0);
    chk("midrst_rdata1", 32'(rd1), 0);
    chk("midrst_rdata2", 32'(rd2), 0);
    chk("midrst_ready1", 32'(ready1), 0);
    chk("midrst_ready2", 32'(ready2), 0);
    q1.delete();
    q2.delete();
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_init("reinit");
    for (int a = 0; a < Depth; a++) rd(AW'(a));
    idle(4);

    chk("queue1_drained", 32'(q1.size()), 0);
    chk("queue2_drained", 32'(q2.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
